eager_fork_ctrl: RTL and testbench

Registered N-way eager fork controller that broadcasts each input token to NUM_OUT consumers without requiring them to be ready in the same cycle. Holds one token and tracks per-branch delivery, so each consumer handshakes independently. The token retires only when every branch has accepted it. Sits between a producer and parallel datapath branches, such as residual and main paths, where lock-step ready coupling would stall or deadlock.

---
 rtl/eager_fork_pkg.sv | 11 +
 rtl/eager_fork_branch.sv | 42 ++++
 rtl/eager_fork_ctrl.sv | 102 ++++++++++
 tb/tb_eager_fork_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eager_fork_pkg.sv
// rtl/eager_fork_pkg.sv - shared types and constants for the eager fork controller (option: EAGER_FORK_PERF_EN)
package eager_fork_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } eager_fork_state_t;

  localparam int PERF_CNT_WIDTH = 16;

endpackage

// File: rtl/eager_fork_branch.sv
// rtl/eager_fork_branch.sv - per-branch pending bit, handshake fire and optional stall counter (option: EAGER_FORK_PERF_EN)
module eager_fork_branch
  import eager_fork_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic ready,
  output logic fire,
  output logic pending
`ifdef EAGER_FORK_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_count
`endif
);

  // A branch only fires while it still owes the consumer the held token.
  assign fire = pending & ready;

  // Pending is set for every new token and cleared once this branch has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end else if (fire) begin
      pending <= 1'b0;
    end
  end

`ifdef EAGER_FORK_PERF_EN
  // Count cycles where this branch owes a token but its consumer is not ready; saturate at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_count <= '0;
    end else if (pending && !ready && (perf_count != '1)) begin
      perf_count <= perf_count + PERF_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: rtl/eager_fork_ctrl.sv
// rtl/eager_fork_ctrl.sv - registered N-way eager fork controller (option: EAGER_FORK_PERF_EN adds stall counters)
module eager_fork_ctrl
  import eager_fork_pkg::*;
#(
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_OUT-1:0]    data_out_valid,
  input  logic [NUM_OUT-1:0]    data_out_ready
`ifdef EAGER_FORK_PERF_EN
  ,
  output logic [NUM_OUT-1:0][PERF_CNT_WIDTH-1:0] perf_stall_cycles
`endif
);

  eager_fork_state_t        state;
  eager_fork_state_t        state_nxt;
  logic [NUM_OUT-1:0]       pending;
  logic [NUM_OUT-1:0]       fire;
  logic [DATA_WIDTH-1:0]    payload;
  logic                     last;
  logic                     load;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_branch
    eager_fork_branch u_branch (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .ready      (data_out_ready[i]),
      .fire       (fire[i]),
      .pending    (pending[i])
`ifdef EAGER_FORK_PERF_EN
      ,
      .perf_count (perf_stall_cycles[i])
`endif
    );
  end

  // The token retires when no branch would still be owed it after this edge.
  assign last = ~|(pending & ~fire);

  assign data_out       = payload;
  assign data_out_valid = pending;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, input handshake and token load; final delivery may overlap a new acceptance.
  always_comb begin
    state_nxt     = state;
    data_in_ready = 1'b0;
    load          = 1'b0;
    case (state)
      EMPTY: begin
        data_in_ready = 1'b1;
        if (data_in_valid) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        data_in_ready = last;
        if (last) begin
          if (data_in_valid) begin
            load = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    if (rst) begin
      data_in_ready = 1'b0;
      load          = 1'b0;
    end
  end

  // Payload holds the broadcast token; it only changes when a new token is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload <= '0;
    end else if (load) begin
      payload <= data_in;
    end
  end

endmodule

// File: tb/tb_eager_fork_ctrl.sv
// tb/tb_eager_fork_ctrl.sv - self-checking bench for eager_fork_ctrl (option: EAGER_FORK_PERF_EN)
module tb_eager_fork_ctrl;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int HMAX = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic [N-1:0]  dout_valid;
  logic [N-1:0]  dout_ready;
`ifdef EAGER_FORK_PERF_EN
  logic [N-1:0][15:0] perf;
`endif

  always #5 clk = ~clk;

  eager_fork_ctrl #(.NUM_OUT(N), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_in_valid  (din_valid),
    .data_in_ready  (din_ready),
    .data_out       (dout),
    .data_out_valid (dout_valid),
    .data_out_ready (dout_ready)
`ifdef EAGER_FORK_PERF_EN
    ,
    .perf_stall_cycles (perf)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one held token, the set of branches that already took it,
  // the history of accepted tokens and how far each branch has consumed it.
  bit            m_have;
  logic [DW-1:0] m_val = '0;
  bit   [N-1:0]  m_done;
  logic [DW-1:0] hist [HMAX];
  int            acc_n = 0;
  int            del_n [N];
  int            pc    [N];
  bit            chk_en = 0;
  bit            acc;
  logic [N-1:0]  ev;

  function automatic bit model_ready();
    if (rst) return 1'b0;
    if (!m_have) return 1'b1;
    for (int i = 0; i < N; i++)
      if (!m_done[i] && !dout_ready[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference update at each clock edge, cleared instantly on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0;
      m_val  = '0;
      m_done = '0;
      for (int i = 0; i < N; i++) begin
        del_n[i] = acc_n;
        pc[i]    = 0;
      end
    end else begin
      acc = model_ready() && din_valid;
      for (int i = 0; i < N; i++) begin
        if (m_have && !m_done[i]) begin
          if (dout_ready[i]) m_done[i] = 1'b1;
          else if (pc[i] < 65535) pc[i]++;
        end
      end
      if (acc) begin
        m_have = 1;
        m_val  = din;
        m_done = '0;
        hist[acc_n % HMAX] = din;
        acc_n++;
      end else if (m_have && (&m_done)) begin
        m_have = 0;
      end
    end
  end

  // Compare DUT outputs against the reference away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      ev = m_have ? ~m_done : '0;
      chk("din_ready", din_ready, model_ready());
      chk("dout_valid", dout_valid, ev);
      chk("dout", dout, m_val);
      for (int i = 0; i < N; i++) begin
        if (dout_valid[i] && dout_ready[i]) begin
          chk($sformatf("no_extra_delivery_b%0d", i), del_n[i] < acc_n, 1'b1);
          if (del_n[i] < acc_n) begin
            chk($sformatf("deliver_order_b%0d", i), dout, hist[del_n[i] % HMAX]);
            del_n[i]++;
          end
        end
`ifdef EAGER_FORK_PERF_EN
        chk($sformatf("perf_b%0d", i), perf[i], pc[i]);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  ready_cnt;
  int  d0;
  bit  accepted_prev;

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = '0;
    for (int i = 0; i < N; i++) begin
      del_n[i] = 0;
      pc[i]    = 0;
    end
    #1;
    chk_en = 1;

    // Reset state
    @(negedge clk);
    chk("rst_din_ready", din_ready, 1'b0);
    chk("rst_dout_valid", dout_valid, 3'b000);
    chk("rst_dout", dout, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_din_ready", din_ready, 1'b1);
    tick();

    // Full rate streaming 1..8
    dout_ready = '1;
    ready_cnt  = 0;
    d0         = del_n[0];
    for (int k = 1; k <= 8; k++) begin
      din       = k;
      din_valid = 1'b1;
      @(negedge clk);
      if (din_ready) ready_cnt++;
      tick();
    end
    din_valid = 1'b0;
    @(negedge clk);
    chk("full_rate_last_dout", dout, 32'h8);
    tick();
    chk("full_rate_ready_cycles", ready_cnt, 8);
    chk("full_rate_b0_deliveries", del_n[0] - d0, 8);

    // Skewed branch readiness
    dout_ready = '0;
    din        = 32'hA5;
    din_valid  = 1'b1;
    tick();
    din_valid  = 1'b0;
    dout_ready = 3'b001;
    @(negedge clk);
    chk("skew_c1_valid", dout_valid, 3'b111);
    chk("skew_c1_dout", dout, 32'hA5);
    chk("skew_c1_ready", din_ready, 1'b0);
    tick();
    dout_ready = 3'b000;
    @(negedge clk);
    chk("skew_c2_valid", dout_valid, 3'b110);
    tick();
    @(negedge clk);
    chk("skew_c3_ready", din_ready, 1'b0);
    tick();
    dout_ready = 3'b110;
    @(negedge clk);
    chk("skew_c4_ready", din_ready, 1'b1);
    tick();
    dout_ready = 3'b000;
    @(negedge clk);
    chk("skew_c5_valid", dout_valid, 3'b000);
    tick();

    // Back-to-back at final delivery
    din       = 32'h11;
    din_valid = 1'b1;
    tick();
    din_valid  = 1'b0;
    dout_ready = 3'b011;
    tick();
    dout_ready = 3'b100;
    din        = 32'h3C;
    din_valid  = 1'b1;
    @(negedge clk);
    chk("b2b_ready", din_ready, 1'b1);
    tick();
    din_valid  = 1'b0;
    dout_ready = 3'b000;
    @(negedge clk);
    chk("b2b_valid", dout_valid, 3'b111);
    chk("b2b_dout", dout, 32'h3C);
    tick();
    dout_ready = '1;
    tick();

    // No duplication on a branch held ready
    dout_ready = '0;
    din        = 32'h5A;
    din_valid  = 1'b1;
    tick();
    din_valid  = 1'b0;
    dout_ready = 3'b100;
    d0         = del_n[2];
    repeat (5) tick();
    @(negedge clk);
    chk("nodup_b2_count", del_n[2] - d0, 1);
    chk("nodup_valid", dout_valid, 3'b011);
    tick();
    dout_ready = '1;
    tick();

    // Reset mid-token with only branch0 still pending
    dout_ready = '0;
    din        = 32'h99;
    din_valid  = 1'b1;
    tick();
    din_valid  = 1'b0;
    dout_ready = 3'b110;
    tick();
    dout_ready = 3'b000;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", dout_valid, 3'b000);
    chk("midrst_dout", dout, 32'h0);
    chk("midrst_ready", din_ready, 1'b0);
    tick();
    rst        = 1'b0;
    dout_ready = '1;
    @(negedge clk);
    chk("midrst_after_ready", din_ready, 1'b1);
    chk("midrst_after_valid", dout_valid, 3'b000);
    repeat (3) tick();

`ifdef EAGER_FORK_PERF_EN
    // Saturating stall counter on a long-stalled branch
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    dout_ready = 3'b101;
    din        = 32'h77;
    din_valid  = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (70000) tick();
    @(negedge clk);
    chk("perf_sat_b1", perf[1], 16'hFFFF);
    chk("perf_zero_b0", perf[0], 16'h0000);
    tick();
    dout_ready = '1;
    tick();
`endif

    // Randomized traffic with occasional resets
    accepted_prev = 1'b1;
    din_valid     = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!din_valid || accepted_prev) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din       = $urandom;
      end
      for (int i = 0; i < N; i++)
        dout_ready[i] = ($urandom_range(0, 9) < (3 + 3 * ((c / 1000 + i) % 3)));
      if ((c % 737) == 500) begin
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      @(negedge clk);
      accepted_prev = din_valid && din_ready;
      tick();
    end
    din_valid  = 1'b0;
    dout_ready = '1;
    repeat (3) tick();
    for (int i = 0; i < N; i++)
      chk($sformatf("drain_b%0d", i), del_n[i], acc_n);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
